// File: rtl/mul_div_ctrl.sv
// Sequencing controller between an RV32M request port and an unsigned-magnitude mul/div core.
// Optional: define MUL_DIV_CTRL_DIV_SHORTCUT_EN to resolve divide-by-zero / signed-overflow without the core.
module mul_div_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        busy,
    output logic        core_enable_in,
    output logic [31:0] core_x,
    output logic [31:0] core_y,
    output logic        core_mul0_div1,
    output logic        core_x_signed0_unsigned1,
    output logic        core_y_signed0_unsigned1,
    input  logic        core_enable_out,
    input  logic [63:0] core_z,
    input  logic [31:0] core_q,
    input  logic [31:0] core_r
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        w_accept;
    logic        w_capture;
    logic        w_result_load;

    // Request as accepted; sign fixup in FIX works from these, not from the live inputs.
    logic [2:0]  r_funct3;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;

    logic [31:0] r_core_x;
    logic [31:0] r_core_y;
    logic        r_mul0_div1;
    logic        r_x_unsigned;
    logic        r_y_unsigned;

    logic [63:0] r_z;
    logic [31:0] r_q;
    logic [31:0] r_r;

    logic [31:0] r_result;

    logic        w_in_x_signed;
    logic        w_in_y_signed;
    logic [31:0] w_in_x_mag;
    logic [31:0] w_in_y_mag;

    logic        w_mul_neg;
    logic [63:0] w_prod;
    logic        w_div_signed;
    logic        w_div_by_zero;
    logic        w_div_overflow;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_fix_result;

    // Operand signedness for the incoming request.
    always_comb begin
        w_in_x_signed = 1'b0;
        w_in_y_signed = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_in_x_signed = 1'b1;
                w_in_y_signed = 1'b1;
            end
            3'b010: begin
                w_in_x_signed = 1'b1;
            end
            default: begin
                w_in_x_signed = 1'b0;
                w_in_y_signed = 1'b0;
            end
        endcase
    end

    assign w_in_x_mag = (w_in_x_signed && rs1[31]) ? (32'd0 - rs1) : rs1;
    assign w_in_y_mag = (w_in_y_signed && rs2[31]) ? (32'd0 - rs2) : rs2;

`ifdef MUL_DIV_CTRL_DIV_SHORTCUT_EN
    logic w_in_special;
    assign w_in_special = funct3[2] &&
                          ((rs2 == 32'd0) ||
                           (!funct3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF)));
`endif

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        w_result_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
`ifdef MUL_DIV_CTRL_DIV_SHORTCUT_EN
                    w_state_next = w_in_special ? FIX : ISSUE;
`else
                    w_state_next = ISSUE;
`endif
                end
            end
            ISSUE: begin
                w_state_next = WAIT;
            end
            WAIT: begin
                if (core_enable_out) begin
                    w_capture    = 1'b1;
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_result_load = 1'b1;
                w_state_next  = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_funct3     <= 3'd0;
            r_rs1        <= 32'd0;
            r_rs2        <= 32'd0;
            r_core_x     <= 32'd0;
            r_core_y     <= 32'd0;
            r_mul0_div1  <= 1'b0;
            r_x_unsigned <= 1'b0;
            r_y_unsigned <= 1'b0;
        end else if (w_accept) begin
            r_funct3     <= funct3;
            r_rs1        <= rs1;
            r_rs2        <= rs2;
            r_core_x     <= w_in_x_mag;
            r_core_y     <= w_in_y_mag;
            r_mul0_div1  <= funct3[2];
            r_x_unsigned <= ~w_in_x_signed;
            r_y_unsigned <= ~w_in_y_signed;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_z <= 64'd0;
            r_q <= 32'd0;
            r_r <= 32'd0;
        end else if (w_capture) begin
            r_z <= core_z;
            r_q <= core_q;
            r_r <= core_r;
        end
    end

    // Sign restoration of the magnitude results, with RV32M special cases taking priority.
    assign w_mul_neg      = (~r_x_unsigned & r_rs1[31]) ^ (~r_y_unsigned & r_rs2[31]);
    assign w_prod         = w_mul_neg ? (64'd0 - r_z) : r_z;
    assign w_div_signed   = ~r_funct3[0];
    assign w_div_by_zero  = (r_rs2 == 32'd0);
    assign w_div_overflow = w_div_signed && (r_rs1 == 32'h8000_0000) && (r_rs2 == 32'hFFFF_FFFF);
    assign w_quot         = (w_div_signed && (r_rs1[31] ^ r_rs2[31])) ? (32'd0 - r_q) : r_q;
    assign w_rem          = (w_div_signed && r_rs1[31]) ? (32'd0 - r_r) : r_r;

    always_comb begin
        w_fix_result = 32'd0;
        if (!r_funct3[2]) begin
            w_fix_result = (r_funct3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];
        end else if (w_div_by_zero) begin
            w_fix_result = r_funct3[1] ? r_rs1 : 32'hFFFF_FFFF;
        end else if (w_div_overflow) begin
            w_fix_result = r_funct3[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            w_fix_result = r_funct3[1] ? w_rem : w_quot;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_result <= 32'd0;
        end else if (w_result_load) begin
            r_result <= w_fix_result;
        end
    end

    assign req_ready                = (r_state == IDLE);
    assign busy                     = (r_state != IDLE);
    assign core_enable_in           = (r_state == ISSUE);
    assign result_valid             = (r_state == DONE);
    assign result                   = r_result;
    assign core_x                   = r_core_x;
    assign core_y                   = r_core_y;
    assign core_mul0_div1           = r_mul0_div1;
    assign core_x_signed0_unsigned1 = r_x_unsigned;
    assign core_y_signed0_unsigned1 = r_y_unsigned;

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Self-checking bench for mul_div_ctrl: behavioural mul/div core, RV32M reference model and result scoreboard.
module tb_mul_div_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        result_valid;
    logic [31:0] result;
    logic        busy;
    logic        core_enable_in;
    logic [31:0] core_x;
    logic [31:0] core_y;
    logic        core_mul0_div1;
    logic        core_x_signed0_unsigned1;
    logic        core_y_signed0_unsigned1;
    logic        core_enable_out;
    logic [63:0] core_z;
    logic [31:0] core_q;
    logic [31:0] core_r;

`ifdef MUL_DIV_CTRL_DIV_SHORTCUT_EN
    localparam bit SHORTCUT = 1'b1;
`else
    localparam bit SHORTCUT = 1'b0;
`endif

    mul_div_ctrl dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .req_valid                (req_valid),
        .req_ready                (req_ready),
        .funct3                   (funct3),
        .rs1                      (rs1),
        .rs2                      (rs2),
        .result_valid             (result_valid),
        .result                   (result),
        .busy                     (busy),
        .core_enable_in           (core_enable_in),
        .core_x                   (core_x),
        .core_y                   (core_y),
        .core_mul0_div1           (core_mul0_div1),
        .core_x_signed0_unsigned1 (core_x_signed0_unsigned1),
        .core_y_signed0_unsigned1 (core_y_signed0_unsigned1),
        .core_enable_out          (core_enable_out),
        .core_z                   (core_z),
        .core_q                   (core_q),
        .core_r                   (core_r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Architectural RV32M result, computed directly from the operands.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        xe;
        logic [63:0]        ye;
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sres;
        sa = a;
        sb = b;
        xe = (f == 3'b011) ? {32'd0, a} : {{32{a[31]}}, a};
        ye = (f[1] == 1'b1) ? {32'd0, b} : {{32{b[31]}}, b};
        p  = xe * ye;
        ref_res = 32'd0;
        case (f)
            3'b000: ref_res = p[31:0];
            3'b001, 3'b010, 3'b011: ref_res = p[63:32];
            3'b100: begin
                if (b == 32'd0) ref_res = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_res = 32'h8000_0000;
                else begin sres = sa / sb; ref_res = sres; end
            end
            3'b101: ref_res = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) ref_res = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_res = 32'd0;
                else begin sres = sa % sb; ref_res = sres; end
            end
            default: ref_res = (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Behavioural core: magnitudes in, unsigned results out after core_lat cycles.
    int          core_lat    = 1;
    bit          stray       = 1'b0;
    int          cm_cnt      = 0;
    int          pulse_cyc   = -100;
    int          issue_count = 0;
    logic [31:0] cm_x;
    logic [31:0] cm_y;

    initial begin
        core_enable_out = 1'b0;
        core_z = 64'd0;
        core_q = 32'd0;
        core_r = 32'd0;
        forever begin
            @(negedge clk);
            core_enable_out = 1'b0;
            if (core_enable_in) issue_count++;
            if (cm_cnt > 0) begin
                cm_cnt--;
                if (cm_cnt == 0) begin
                    core_enable_out = 1'b1;
                    core_z    = {32'd0, cm_x} * {32'd0, cm_y};
                    core_q    = (cm_y == 32'd0) ? 32'hFFFF_FFFF : cm_x / cm_y;
                    core_r    = (cm_y == 32'd0) ? cm_x : cm_x % cm_y;
                    pulse_cyc = cyc;
                end
            end else if (core_enable_in) begin
                cm_x   = core_x;
                cm_y   = core_y;
                cm_cnt = core_lat;
                if (stray) begin
                    core_enable_out = 1'b1;
                    core_z = 64'hDEAD_BEEF_0BAD_F00D;
                    core_q = 32'h1234_5678;
                    core_r = 32'h8765_4321;
                end
            end
        end
    end

    typedef struct {
        logic [31:0] res;
        bit          sc;
        int          acc_cyc;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    bit          prev_rv  = 1'b0;
    bit          hold_en  = 1'b0;
    logic [31:0] last_res = 32'd0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (result_valid) begin
                chk("rv_one_cycle", prev_rv, 1'b0);
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({e.tag, "_result"}, result, e.res);
                    chk({e.tag, "_latency"}, cyc, e.sc ? e.acc_cyc + 2 : pulse_cyc + 2);
                    $display("txn %s result=0x%08h expected=0x%08h cycle=%0d", e.tag, result, e.res, cyc);
                end
                last_res = result;
            end else if (hold_en) begin
                chk("result_hold", result, last_res);
            end
            prev_rv = result_valid;
        end
    end

    // Caller sits at a negedge; returns at the negedge after DONE with the DUT idle.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input bit str);
        exp_t        e;
        int          n;
        bit          sc;
        bit          xs;
        bit          ys;
        int          issues_before;
        logic [31:0] xm;
        logic [31:0] ym;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, req_ready, 1'b1);
        sc = SHORTCUT && is_special(f, a, b);
        xs = (f == 3'b000 || f == 3'b001 || f == 3'b010 || f == 3'b100 || f == 3'b110);
        ys = (f == 3'b000 || f == 3'b001 || f == 3'b100 || f == 3'b110);
        xm = (xs && a[31]) ? -a : a;
        ym = (ys && b[31]) ? -b : b;
        core_lat = lat;
        stray    = str;
        req_valid = 1'b1;
        funct3    = f;
        rs1       = a;
        rs2       = b;
        e.res = ref_res(f, a, b);
        e.sc  = sc;
        e.acc_cyc = cyc;
        e.tag = tag;
        sb.push_back(e);
        issues_before = issue_count;
        @(negedge clk);
        // Keep a different request asserted while busy; it must not be taken.
        funct3 = ~f;
        rs1    = ~a;
        rs2    = b ^ 32'h5A5A_5A5A;
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_not_ready"}, req_ready, 1'b0);
        if (sc) begin
            chk({tag, "_no_issue"}, core_enable_in, 1'b0);
        end else begin
            chk({tag, "_issue"}, core_enable_in, 1'b1);
            chk({tag, "_core_x"}, core_x, xm);
            chk({tag, "_core_y"}, core_y, ym);
            chk({tag, "_mode_md"}, core_mul0_div1, f[2]);
            chk({tag, "_mode_xu"}, core_x_signed0_unsigned1, !xs);
            chk({tag, "_mode_yu"}, core_y_signed0_unsigned1, !ys);
        end
        n = 0;
        while (!result_valid && n < 60) begin @(negedge clk); n++; end
        chk({tag, "_done"}, result_valid, 1'b1);
        req_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_after_done"}, req_ready, 1'b1);
        chk({tag, "_issue_count"}, issue_count - issues_before, sc ? 0 : 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        funct3    = 3'd0;
        rs1       = 32'd0;
        rs2       = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_result", result, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_enable_in", core_enable_in, 1'b0);
        chk("rst_core_x", core_x, 32'd0);
        chk("rst_core_y", core_y, 32'd0);
        chk("rst_modes", {core_mul0_div1, core_x_signed0_unsigned1, core_y_signed0_unsigned1}, 3'b000);
        chk("rst_req_ready", req_ready, 1'b1);
        reset_n  = 1'b1;
        last_res = 32'd0;
        hold_en  = 1'b1;

        do_op("mul_neg",   3'b000, 32'hFFFF_FFFD, 32'd7,         1, 1'b1);
        do_op("mulh_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 2, 1'b0);
        do_op("div_neg",   3'b100, 32'hFFFF_FFF9, 32'd2,         1, 1'b0);
        do_op("rem_neg",   3'b110, 32'hFFFF_FFF9, 32'd2,         1, 1'b1);
        do_op("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b0);
        do_op("mulhu",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
        do_op("divu_zero", 3'b101, 32'd5,         32'd0,         2, 1'b0);
        do_op("remu_zero", 3'b111, 32'd5,         32'd0,         1, 1'b0);
        do_op("div_zero",  3'b100, 32'hFFFF_FFF0, 32'd0,         1, 1'b0);
        do_op("rem_zero",  3'b110, 32'hFFFF_FFF0, 32'd0,         1, 1'b0);
        do_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
        do_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0);
        do_op("divu_big",  3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);

        // Reset while the core is still working; its late done strobe must be dropped.
        chk("wrst_ready", req_ready, 1'b1);
        core_lat  = 6;
        stray     = 1'b0;
        req_valid = 1'b1;
        funct3    = 3'b100;
        rs1       = 32'd100;
        rs2       = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("wrst_busy_in_wait", busy, 1'b1);
        hold_en = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("wrst_req_ready", req_ready, 1'b1);
        chk("wrst_busy", busy, 1'b0);
        chk("wrst_result", result, 32'd0);
        chk("wrst_core_x", core_x, 32'd0);
        chk("wrst_core_enable_in", core_enable_in, 1'b0);
        last_res = 32'd0;
        hold_en  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("wrst_idle_ready", req_ready, 1'b1);
            chk("wrst_no_result", result_valid, 1'b0);
        end
        $display("txn wait_reset late_core_pulse_cycle=%0d", pulse_cyc);

        do_op("post_rst_mul", 3'b000, 32'd12345, 32'd678, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'd0;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'hFFFF_FFFF;
                1: rb = 32'd0;
                2: rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            do_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
